// File: rtl/mult_sequencer_if.sv
// Handshake, operand/product and shared-ALU bundle for mult_sequencer.
// The ovf flag exists only when MULT_SEQ_OVF_EN is defined.
interface mult_sequencer_if #(
  parameter int unsigned length = 32
);
  logic              start;
  logic [length-1:0] a;
  logic [length-1:0] b;
  logic              busy;
  logic              done;
  logic [length-1:0] o;
  logic [length-1:0] alu_a;
  logic [length-1:0] alu_b;
  logic [3:0]        alu_s;
  logic [length-1:0] alu_o;
  logic              alu_of;
`ifdef MULT_SEQ_OVF_EN
  logic              ovf;

  modport master (
    output start, a, b, alu_o, alu_of,
    input  busy, done, o, alu_a, alu_b, alu_s, ovf
  );
  modport slave (
    input  start, a, b, alu_o, alu_of,
    output busy, done, o, alu_a, alu_b, alu_s, ovf
  );
`else
  modport master (
    output start, a, b, alu_o, alu_of,
    input  busy, done, o, alu_a, alu_b, alu_s
  );
  modport slave (
    input  start, a, b, alu_o, alu_of,
    output busy, done, o, alu_a, alu_b, alu_s
  );
`endif
endinterface

// File: rtl/mult_sequencer.sv
// Shift-and-add multiplier sequencing an external combinational ALU.
// Optional sticky overflow flag enabled by defining MULT_SEQ_OVF_EN.
module mult_sequencer #(
  parameter int unsigned length = 32
) (
  input  logic            clk,
  input  logic            rst,
  mult_sequencer_if.slave bus
);
  localparam int unsigned IW = (length > 2) ? $clog2(length) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, SHIFT, ADD, DONE} state_t;

  state_t            state, state_nx;
  logic [length-1:0] a_reg, b_reg, sum, tmp, o_reg;
  logic [IW-1:0]     i;
  logic              last;
  logic              busy, done;
  logic [length-1:0] alu_a, alu_b;
  logic [3:0]        alu_s;

  assign last = (i == IW'(length - 1));

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_s    = '0;
    case (state)
      IDLE:  if (bus.start) state_nx = CHECK;
      CHECK: begin
        busy = 1'b1;
        if (b_reg[i])  state_nx = SHIFT;
        else if (last) state_nx = DONE;
      end
      SHIFT: begin
        busy     = 1'b1;
        alu_a    = a_reg;
        alu_b    = length'(i);
        alu_s    = 4'd2;
        state_nx = ADD;
      end
      ADD: begin
        busy     = 1'b1;
        alu_a    = sum;
        alu_b    = tmp;
        alu_s    = 4'd0;
        state_nx = last ? DONE : CHECK;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef MULT_SEQ_OVF_EN
  logic ovf;
  assign bus.ovf = ovf;
`else
  logic unused_alu_of;
  assign unused_alu_of = bus.alu_of;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
      tmp   <= '0;
      o_reg <= '0;
      i     <= '0;
`ifdef MULT_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.start) begin
          a_reg <= bus.a;
          b_reg <= bus.b;
          sum   <= '0;
          o_reg <= '0;
          i     <= '0;
`ifdef MULT_SEQ_OVF_EN
          ovf   <= 1'b0;
`endif
        end
        CHECK: if (!b_reg[i]) begin
          i <= i + 1'b1;
          if (last) o_reg <= sum;
        end
        SHIFT: begin
          tmp <= bus.alu_o;
`ifdef MULT_SEQ_OVF_EN
          // Shifting back down must recover a_reg, otherwise bits fell off the top
          if ((bus.alu_o >> i) != a_reg) ovf <= 1'b1;
`endif
        end
        ADD: begin
          sum <= bus.alu_o;
          i   <= i + 1'b1;
          // The final partial sum bypasses sum so o is valid together with done
          if (last) o_reg <= bus.alu_o;
`ifdef MULT_SEQ_OVF_EN
          if (bus.alu_of) ovf <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.o     = o_reg;
  assign bus.alu_a = alu_a;
  assign bus.alu_b = alu_b;
  assign bus.alu_s = alu_s;
endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter: length, 32, operand/product width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to multiply a by b; sampled only in IDLE.
REQ-005 Port: a  input  length  multiplicand (unsigned), captured when start is accepted.
REQ-006 Port: b  input  length  multiplier (unsigned), captured when start is accepted.
REQ-007 Port: busy  output  1  high in CHECK, SHIFT, ADD.
REQ-008 Port: done  output  1  one-cycle pulse in DONE.
REQ-009 Port: o  output  length  product register; holds its value until the next accepted start or reset.
REQ-010 Port: alu_a, alu_b  output  length  operands driven to the shared combinational ALU.
REQ-011 Port: alu_s  output  4  ALU opcode; 0 = add, 2 = shift-left a by b.
REQ-012 Port: alu_o  input  length  ALU result, valid combinationally in the same cycle.
REQ-013 Port: alu_of  input  1  ALU add-overflow flag, valid combinationally in the same cycle.

Function
REQ-014 The FSM SHALL have the states IDLE, CHECK, SHIFT, ADD, DONE.
REQ-015 IDLE with start=1: capture a and b into internal registers; clear sum, o, bit index i and ovf; go to CHECK.
REQ-016 CHECK: if b_reg[i]=1, go to SHIFT; else increment i, and go to DONE if i was length-1, otherwise stay in CHECK.
REQ-017 SHIFT: drive alu_a=a_reg, alu_b=i, alu_s=2; register alu_o into tmp; go to ADD.
REQ-018 ADD: drive alu_a=sum, alu_b=tmp, alu_s=0; register alu_o into sum; increment i; go to DONE if i was length-1, otherwise go to CHECK.
REQ-019 On the transition into DONE, o SHALL be loaded with the final sum.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-021 In IDLE, CHECK and DONE, alu_a, alu_b and alu_s SHALL be driven to 0.
REQ-022 Latency: with start sampled at edge 0, done is high in the cycle after edge N, where N = length + 2*popcount(b).
REQ-023 start SHALL be ignored in CHECK, SHIFT, ADD and DONE; captured operands are never altered mid-operation.
REQ-024 All arithmetic is unsigned modulo 2^length; o holds the low length bits of a*b.
REQ-025 b=0 SHALL still visit all length CHECK cycles; a=0 SHALL NOT shorten the sequence.

Reset
REQ-026 With rst=1 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, o=0, sum=0, i=0, ovf=0, and alu_a/alu_b/alu_s=0.
REQ-027 rst SHALL override start in the same cycle and SHALL abort an operation in progress with no done pulse.

Configuration
REQ-028 Macro MULT_SEQ_OVF_EN defined: add port ovf (output, 1 bit), a sticky flag cleared on reset and on an accepted start.
REQ-029 With MULT_SEQ_OVF_EN, ovf SHALL be set in SHIFT when (alu_o >> i) != a_reg, and in ADD when alu_of=1.
REQ-030 With MULT_SEQ_OVF_EN, ovf SHALL be valid with done and held until the next accepted start or reset.
REQ-031 Macro MULT_SEQ_OVF_EN undefined: no ovf port and no overflow logic; all other behaviour unchanged.

Verification (length=32, bench supplies a reference ALU model)
REQ-032 a=3, b=12 -> o=36; done in the cycle after edge 36; busy high for 36 cycles.
REQ-033 a=0xFFFFFFFF, b=0 -> o=0; done in the cycle after edge 32; SHIFT and ADD never entered.
REQ-034 a=0x0000FFFF, b=0x00010001 -> o=0xFFFFFFFF, ovf=0; a=0x80000000, b=2 -> o=0, ovf=1.
REQ-035 a=5, b=7 with start held high during the operation and in DONE -> o=35, exactly one done pulse, no restart until IDLE.
REQ-036 rst pulse at edge 10 of a=9, b=0xFF -> o=0, busy=0, no done; next start a=9, b=0xFF -> o=2295.
